// File: rtl/sram_access_ctrl_pkg.sv
// ============================================================================
// Module      : sram_access_ctrl_pkg
// Description : Shared types and constants for the MEM-stage SRAM access
//               controller: FSM state encoding, default memory base address
//               and SRAM data width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_access_ctrl_pkg;

  // Access sequencer states: one low-half phase, one high-half phase, then a
  // single DONE cycle in which the pipeline is released.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte address that maps to SRAM word 0.
  localparam int MEM_BASE_DEFAULT = 1024;

  // External SRAM data bus width (one half of a 32-bit word).
  localparam int SRAM_DW = 16;

endpackage

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// ============================================================================
// Module      : sram_access_ctrl
// Description : Sequences 32-bit MEM-stage loads/stores onto a 16-bit
//               single-port SRAM as two half-word phases, each held for
//               WAIT+1 cycles. 'ready' low freezes the pipeline around the
//               MEM stage until the access has completed.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous reset, active-low
//   rd_en        in   load request, held until ready
//   wr_en        in   store request, held until ready (wins over rd_en)
//   address      in   32-bit word-aligned byte address
//   write_data   in   32-bit store data
//   read_data    out  32-bit assembled load data (holds until next load)
//   ready        out  high when no access is in progress (combinational)
//   sram_addr    out  SRAM half-word address
//   sram_dq_out  out  data driven to the SRAM
//   sram_dq_oe   out  output enable for sram_dq_out
//   sram_we_n    out  SRAM write strobe, active-low, registered
//   sram_dq_in   in   data returned from the SRAM
// ============================================================================
`default_nettype none

module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int WAIT     = 1,
  parameter int MEM_BASE = MEM_BASE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  output logic                sram_we_n,
  input  logic [SRAM_DW-1:0]  sram_dq_in
);

  // Counter must hold 0..WAIT; keep at least one bit when WAIT is zero.
  localparam int               CNT_W    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT);
  localparam int               IDX_W    = ADDR_W - 1;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               is_write_q;

  logic               req;
  logic               phase_last;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx_in;
  logic               unused_offset_bits;

  assign req        = rd_en | wr_en;
  assign phase_last = (cnt_q == CNT_LAST);

  // Word index relative to the SRAM window, truncated to the address space.
  assign offset             = address - 32'(MEM_BASE);
  assign idx_in             = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and the combinational ready output
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending request must stall the pipeline in the very cycle it is
        // seen, otherwise the MEM stage would advance past it.
        ready = !req;
        if (req) begin
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (phase_last) begin
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (phase_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Request is still asserted here; it is dropped by the pipeline on
        // this edge, so never restart from DONE.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase cycle counter: cleared on every state change, counts within phases
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == ST_LO) || (state_q == ST_HI)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch, SRAM pin registers and load data assembly. Pin values are
  // loaded on the edge that enters each phase so they are stable for the
  // whole phase and sram_we_n comes straight from a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            idx_q       <= idx_in;
            wdata_q     <= write_data;
            is_write_q  <= wr_en;
            sram_addr   <= {idx_in, 1'b0};
            sram_dq_out <= write_data[SRAM_DW-1:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= !wr_en;
          end
        end
        ST_LO: begin
          if (phase_last) begin
            if (!is_write_q) begin
              read_data[SRAM_DW-1:0] <= sram_dq_in;
            end
            sram_addr   <= {idx_q, 1'b1};
            sram_dq_out <= wdata_q[2*SRAM_DW-1:SRAM_DW];
          end
        end
        ST_HI: begin
          if (phase_last) begin
            if (!is_write_q) begin
              read_data[2*SRAM_DW-1:SRAM_DW] <= sram_dq_in;
            end
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// ============================================================================
// Module      : tb_sram_access_ctrl
// Description : Self-checking bench for sram_access_ctrl. Two instances are
//               exercised (WAIT=1 and WAIT=0), each attached to a small SRAM
//               model. A cycle-level behavioural model derives the expected
//               pin values from the access timeline; directed vectors add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd, wr, rdy, oe, wen;
  logic [31:0] adr   [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic [17:0] sa    [2];
  logic [15:0] dqo   [2];
  logic [15:0] dqi   [2];

  logic [15:0] sram_mem [2][256];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, one set per instance
  logic        m_busy [2];
  int          m_k    [2];
  logic        m_wr   [2];
  logic [31:0] m_idx  [2];
  logic [31:0] m_data [2];
  logic [31:0] m_rd   [2];
  logic [31:0] model_mem [2][64];

  // Per-cycle log of the most recent directed access
  logic [17:0] sa_log [40];
  logic [15:0] dq_log [40];

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(18), .WAIT(1), .MEM_BASE(1024)) dut_w1 (
    .clk(clk), .rst(rst), .rd_en(rd[0]), .wr_en(wr[0]),
    .address(adr[0]), .write_data(wd[0]), .read_data(rdata[0]),
    .ready(rdy[0]), .sram_addr(sa[0]), .sram_dq_out(dqo[0]),
    .sram_dq_oe(oe[0]), .sram_we_n(wen[0]), .sram_dq_in(dqi[0])
  );

  sram_access_ctrl #(.ADDR_W(18), .WAIT(0), .MEM_BASE(1024)) dut_w0 (
    .clk(clk), .rst(rst), .rd_en(rd[1]), .wr_en(wr[1]),
    .address(adr[1]), .write_data(wd[1]), .read_data(rdata[1]),
    .ready(rdy[1]), .sram_addr(sa[1]), .sram_dq_out(dqo[1]),
    .sram_dq_oe(oe[1]), .sram_we_n(wen[1]), .sram_dq_in(dqi[1])
  );

  // Asynchronous-read SRAM models, written on the clock while we_n is low
  assign dqi[0] = sram_mem[0][sa[0][7:0]];
  assign dqi[1] = sram_mem[1][sa[1][7:0]];

  always @(posedge clk) begin
    if (!wen[0]) sram_mem[0][sa[0][7:0]] <= dqo[0];
    if (!wen[1]) sram_mem[1][sa[1][7:0]] <= dqo[1];
  end

  function automatic logic [31:0] z1(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model and per-cycle compare. A request accepted at cycle 0
  // occupies LO at cycles 1..W+1, HI at W+2..2W+2 and DONE at 2W+3.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          w;
      logic        hi;
      logic [17:0] esa;
      string       p;
      w = (d == 0) ? 1 : 0;
      p = $sformatf("d%0d_", d);
      if (!rst) begin
        chk({p, "rst_ready"}, z1(rdy[d]), z1(~(rd[d] | wr[d])));
        chk({p, "rst_we_n"},  z1(wen[d]), 32'd1);
        chk({p, "rst_oe"},    z1(oe[d]),  32'd0);
        chk({p, "rst_addr"},  {14'b0, sa[d]},  32'd0);
        chk({p, "rst_dq"},    {16'b0, dqo[d]}, 32'd0);
        chk({p, "rst_rdata"}, rdata[d], 32'd0);
        m_busy[d] = 1'b0;
        m_rd[d]   = 32'd0;
      end else if (!m_busy[d]) begin
        chk({p, "idle_ready"}, z1(rdy[d]), z1(~(rd[d] | wr[d])));
        chk({p, "idle_we_n"},  z1(wen[d]), 32'd1);
        chk({p, "idle_oe"},    z1(oe[d]),  32'd0);
        chk({p, "idle_rdata"}, rdata[d],   m_rd[d]);
        if (rd[d] | wr[d]) begin
          m_busy[d] = 1'b1;
          m_k[d]    = 1;
          m_wr[d]   = wr[d];
          m_idx[d]  = ((adr[d] - 32'd1024) >> 2) & 32'h0001_FFFF;
          m_data[d] = wd[d];
          if (wr[d]) model_mem[d][m_idx[d][5:0]] = wd[d];
        end
      end else if (m_k[d] == 2 * w + 3) begin
        chk({p, "done_ready"}, z1(rdy[d]), 32'd1);
        chk({p, "done_we_n"},  z1(wen[d]), 32'd1);
        chk({p, "done_oe"},    z1(oe[d]),  32'd0);
        if (!m_wr[d]) m_rd[d] = model_mem[d][m_idx[d][5:0]];
        chk({p, "done_rdata"}, rdata[d], m_rd[d]);
        m_busy[d] = 1'b0;
      end else begin
        hi  = (m_k[d] >= w + 2);
        esa = {m_idx[d][16:0], hi};
        chk({p, "phase_ready"}, z1(rdy[d]), 32'd0);
        chk({p, "phase_we_n"},  z1(wen[d]), z1(~m_wr[d]));
        chk({p, "phase_oe"},    z1(oe[d]),  z1(m_wr[d]));
        chk({p, "phase_addr"},  {14'b0, sa[d]}, {14'b0, esa});
        if (m_wr[d]) begin
          chk({p, "phase_dq"}, {16'b0, dqo[d]},
              {16'b0, hi ? m_data[d][31:16] : m_data[d][15:0]});
          chk({p, "phase_rdata"}, rdata[d], m_rd[d]);
        end
        m_k[d] = m_k[d] + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // One complete access: request held until ready, address/data scrambled
  // after acceptance, request dropped on the DONE edge.
  // --------------------------------------------------------------------------
  task automatic do_access(input int d, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] data,
                           output int low, output int wl, output logic [31:0] got);
    bit done;
    done = 1'b0;
    low  = 0;
    wl   = 0;
    got  = 32'd0;
    @(posedge clk); #1;
    rd[d] = r; wr[d] = w; adr[d] = a; wd[d] = data;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      sa_log[n] = sa[d];
      dq_log[n] = dqo[d];
      if (!wen[d]) wl++;
      if (rdy[d]) begin
        done = 1'b1;
        got  = rdata[d];
      end else begin
        low++;
        @(posedge clk); #1;
        if (n == 0) begin
          adr[d] = 32'h0000_5550;
          wd[d]  = 32'hA5A5_5A5A;
        end
      end
    end
    chk($sformatf("d%0d_access_timeout", d), z1(done), 32'd1);
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    int          low, wl, cnt;
    logic [31:0] got, b0, b1;
    logic [7:0]  pat;

    rst = 1'b1;
    rd  = 2'b00;
    wr  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      adr[d] = 32'd0;
      wd[d]  = 32'd0;
    end
    #1 rst = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_ready", z1(rdy[0]), 32'd1);
    chk("reset_we_n",  z1(wen[0]), 32'd1);
    chk("reset_oe",    z1(oe[0]),  32'd0);
    chk("reset_rdata", rdata[0],   32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Idle with no requests
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("idle10_ready", z1(rdy[0]), 32'd1);
      chk("idle10_we_n",  z1(wen[0]), 32'd1);
      chk("idle10_oe",    z1(oe[0]),  32'd0);
    end

    // WAIT=1 write 0xDEADBEEF at 1028 -> half-word addresses 2 and 3
    do_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, low, wl, got);
    chk("wr_ready_low_cycles", low, 32'd5);
    chk("wr_we_low_cycles",    wl,  32'd4);
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("wr_addr_c%0d", n), {14'b0, sa_log[n]}, (n <= 2) ? 32'd2 : 32'd3);
      chk($sformatf("wr_dq_c%0d", n),   {16'b0, dq_log[n]}, (n <= 2) ? 32'h0000_BEEF : 32'h0000_DEAD);
    end

    // Read it back
    do_access(0, 1'b1, 1'b0, 32'd1028, 32'd0, low, wl, got);
    chk("rd_data_at_done",     got, 32'hDEAD_BEEF);
    chk("rd_ready_low_cycles", low, 32'd5);
    chk("rd_we_low_cycles",    wl,  32'd0);

    // Reset during the second HI cycle of a write
    @(posedge clk); #1;
    wr[0] = 1'b1; adr[0] = 32'd1028; wd[0] = 32'hCAFE_F00D;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("midrst_we_n",  z1(wen[0]), 32'd1);
    chk("midrst_ready", z1(rdy[0]), 32'd1);
    chk("midrst_oe",    z1(oe[0]),  32'd0);
    chk("midrst_addr",  {14'b0, sa[0]}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Next read starts cleanly at LO with address 2
    do_access(0, 1'b1, 1'b0, 32'd1028, 32'd0, low, wl, got);
    chk("postrst_lo_addr",   {14'b0, sa_log[1]}, 32'd2);
    chk("postrst_hi_addr",   {14'b0, sa_log[3]}, 32'd3);
    chk("postrst_low_cycles", low, 32'd5);
    chk("postrst_rdata",      got, 32'hCAFE_F00D);

    // Both enables high is a write
    do_access(0, 1'b1, 1'b1, 32'd1024, 32'h1234_5678, low, wl, got);
    chk("both_we_low_cycles", wl, 32'd4);
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("both_addr_c%0d", n), {14'b0, sa_log[n]}, (n <= 2) ? 32'd0 : 32'd1);
      chk($sformatf("both_dq_c%0d", n),   {16'b0, dq_log[n]}, (n <= 2) ? 32'h0000_5678 : 32'h0000_1234);
    end
    chk("both_sram_lo", {16'b0, sram_mem[0][0]}, 32'h0000_5678);
    chk("both_sram_hi", {16'b0, sram_mem[0][1]}, 32'h0000_1234);

    // WAIT=0 instance: preload two words, then back-to-back reads
    do_access(1, 1'b0, 1'b1, 32'd1024, 32'h1111_2222, low, wl, got);
    chk("w0_wr_low_cycles", low, 32'd3);
    chk("w0_we_low_cycles", wl,  32'd2);
    do_access(1, 1'b0, 1'b1, 32'd1028, 32'h3333_4444, low, wl, got);
    chk("w0_wr2_low_cycles", low, 32'd3);

    @(posedge clk); #1;
    rd[1] = 1'b1; adr[1] = 32'd1024;
    cnt = 0; pat = 8'd0; b0 = 32'd0; b1 = 32'd0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      pat[n] = rdy[1];
      if (rdy[1]) begin
        if (cnt == 0) b0 = rdata[1];
        else          b1 = rdata[1];
        cnt++;
      end
      @(posedge clk); #1;
      if (cnt == 1) adr[1] = 32'd1028;
      if (cnt == 2) rd[1]  = 1'b0;
    end
    chk("b2b_ready_pattern", {24'b0, pat}, 32'h0000_0088);
    chk("b2b_rdata_first",   b0, 32'h1111_2222);
    chk("b2b_rdata_second",  b1, 32'h3333_4444);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
